// File: rtl/key_action_gen.sv
// key_action_gen: filters the SoC HID keycode and emits one-cycle Tetris action pulses (DAS/ARR for left/right, fixed-rate soft drop).
// Optional Esc pause toggle is compiled in when KEY_ACTION_PAUSE_EN is defined.
module key_action_gen #(
    parameter int DAS_CYCLES    = 8000000,
    parameter int ARR_CYCLES    = 2500000,
    parameter int SOFT_CYCLES   = 1250000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       mv_left,
    output logic       mv_right,
    output logic       rot_cw,
    output logic       rot_ccw,
    output logic       soft_drop,
    output logic       hard_drop,
    output logic       paused
);
    localparam int MAX_AR = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int MAX_P  = (MAX_AR > SOFT_CYCLES) ? MAX_AR : SOFT_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);
    localparam int SW     = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FIRE, DAS_WAIT, REPEAT, HOLD} state_t;

    state_t        st_q, st_d;
    logic [7:0]    kin, k_q, acc_q, acc_d;
    logic [SW-1:0] stab_q;
    logic [CW-1:0] cnt_q, cnt_d, period;
    logic [5:0]    out_q, out_d, a_new, a_acc;
    logic          ev, lr, hit, held;

    // Action vector bit order: {hard, soft, ccw, cw, right, left}
    function automatic logic [5:0] act_of(input logic [7:0] k);
        return (k == 8'h50) ? 6'b000001 :
               (k == 8'h4F) ? 6'b000010 :
               (k == 8'h52 || k == 8'h1B) ? 6'b000100 :
               (k == 8'h1D) ? 6'b001000 :
               (k == 8'h51) ? 6'b010000 :
               (k == 8'h2C) ? 6'b100000 : 6'b000000;
    endfunction

`ifdef KEY_ACTION_PAUSE_EN
    localparam logic [7:0] ESC = 8'h29;
    logic pause_q, pause_d;
    // Esc still passes the filter while disabled so pause works regardless of enable
    assign kin    = (enable || keycode == ESC) ? keycode : 8'h00;
    assign held   = pause_q;
    assign paused = pause_q;
`else
    assign kin    = enable ? keycode : 8'h00;
    assign held   = 1'b0;
    assign paused = 1'b0;
`endif

    assign ev     = (stab_q == SW'(STABLE_CYCLES)) && (k_q != acc_q);
    assign a_new  = act_of(k_q);
    assign a_acc  = act_of(acc_q);
    assign lr     = |a_acc[1:0];
    assign period = (st_q == DAS_WAIT || (st_q == FIRE && lr)) ? CW'(DAS_CYCLES) :
                    lr ? CW'(ARR_CYCLES) : CW'(SOFT_CYCLES);
    assign hit    = cnt_q >= period;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        out_d = '0;
        acc_d = ev ? k_q : acc_q;
`ifdef KEY_ACTION_PAUSE_EN
        pause_d = (ev && k_q == ESC) ? !pause_q : pause_q;
`endif
        if (!enable) begin
            st_d  = IDLE;
            cnt_d = '0;
`ifdef KEY_ACTION_PAUSE_EN
            acc_d = (k_q == ESC && (acc_q == ESC || ev)) ? ESC : 8'h00;
`else
            acc_d = 8'h00;
`endif
        end else if (ev) begin
            st_d  = (|a_new && !held) ? FIRE : IDLE;
            out_d = held ? 6'b000000 : a_new;
            cnt_d = CW'(1);
        end else if (held) begin
            st_d  = IDLE;
            cnt_d = '0;
        end else if (st_q inside {FIRE, DAS_WAIT, REPEAT}) begin
            if (st_q == FIRE && !(lr || a_acc[4])) begin
                st_d = HOLD;
            end else if (hit) begin
                out_d = a_acc;
                cnt_d = CW'(1);
                st_d  = REPEAT;
            end else begin
                cnt_d = cnt_q + CW'(1);
                st_d  = (st_q != FIRE) ? st_q : lr ? DAS_WAIT : REPEAT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q    <= 8'h00;
            stab_q <= '0;
            acc_q  <= 8'h00;
            st_q   <= IDLE;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            k_q    <= kin;
            stab_q <= (kin != k_q) ? '0 : (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + SW'(1);
            acc_q  <= acc_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

`ifdef KEY_ACTION_PAUSE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pause_q <= 1'b0;
        else          pause_q <= pause_d;
    end
`endif

    assign {hard_drop, soft_drop, rot_ccw, rot_cw, mv_right, mv_left} = out_q;
endmodule

// File: tb/tb_key_action_gen.sv
// tb_key_action_gen: randomized and directed stimulus checked every cycle against a time-based model of the key-to-action rules.
module tb_key_action_gen;
    localparam int DAS = 10, ARR = 4, SOFT = 3, STB = 2;
`ifdef KEY_ACTION_PAUSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    localparam logic [7:0] KEYS [10] = '{8'h00, 8'h50, 8'h4F, 8'h51, 8'h52, 8'h1B, 8'h1D, 8'h2C, 8'h29, 8'h10};

    logic       clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       mv_left, mv_right, rot_cw, rot_ccw, soft_drop, hard_drop, paused;
    logic [5:0] dut_act;

    key_action_gen #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .SOFT_CYCLES(SOFT), .STABLE_CYCLES(STB)) dut (
        .clk(clk), .reset_n(reset_n), .keycode(keycode), .enable(enable),
        .mv_left(mv_left), .mv_right(mv_right), .rot_cw(rot_cw), .rot_ccw(rot_ccw),
        .soft_drop(soft_drop), .hard_drop(hard_drop), .paused(paused)
    );

    always #5 clk = ~clk;
    assign dut_act = {hard_drop, soft_drop, rot_ccw, rot_cw, mv_right, mv_left};

    int         cyc = 0, tests = 0, fails = 0;
    logic [5:0] hist [int];
    int         last_chg = 0, due = -1;
    logic [7:0] m_kq = 8'h00, m_acc = 8'h00;
    logic       m_pause = 1'b0;
    logic [5:0] m_out = '0;

    function automatic logic [5:0] act(input logic [7:0] k);
        case (k)
            8'h50:        return 6'd1;
            8'h4F:        return 6'd2;
            8'h52, 8'h1B: return 6'd4;
            8'h1D:        return 6'd8;
            8'h51:        return 6'd16;
            8'h2C:        return 6'd32;
            default:      return 6'd0;
        endcase
    endfunction

    // Model: a key is accepted once it has been steady STB+1 edges; pulses are scheduled by absolute edge number
    always @(posedge clk) begin
        logic [7:0] kin;
        logic       ev, pp;
        logic [5:0] a;
        cyc++;
        kin   = (enable || (PE && keycode == 8'h29)) ? keycode : 8'h00;
        m_out = '0;
        if (!reset_n) begin
            m_kq = 8'h00; m_acc = 8'h00; last_chg = cyc; due = -1; m_pause = 1'b0;
        end else begin
            ev = (cyc - last_chg > STB) && (m_kq != m_acc);
            pp = m_pause;
            if (PE && ev && m_kq == 8'h29) m_pause = !m_pause;
            if (!enable) begin
                m_acc = (PE && m_kq == 8'h29 && (m_acc == 8'h29 || ev)) ? 8'h29 : 8'h00;
                due = -1;
            end else if (ev) begin
                m_acc = m_kq;
                a = act(m_kq);
                if (!pp && a != 0) begin
                    m_out = a;
                    due = (|a[1:0]) ? cyc + DAS : a[4] ? cyc + SOFT : -1;
                end else due = -1;
            end else if (pp) begin
                due = -1;
            end else if (due == cyc) begin
                a = act(m_acc);
                m_out = a;
                due = cyc + ((|a[1:0]) ? ARR : SOFT);
            end
            if (kin != m_kq) begin
                m_kq = kin; last_chg = cyc;
            end
        end
        #1;
        hist[cyc] = dut_act;
        tests++;
        if (dut_act !== m_out || paused !== m_pause) begin
            fails++;
            $display("FAIL model cyc=%0d act=%b expected=%b paused=%b expected=%b", cyc, dut_act, m_out, paused, m_pause);
        end
        tests++;
        if ($countones(dut_act) > 1) begin
            fails++;
            $display("FAIL onehot cyc=%0d act=%b expected at most one bit", cyc, dut_act);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int npulse(input int b, input int a, input int z);
        int n = 0;
        for (int c = a; c <= z; c++) if (hist.exists(c) && hist[c][b]) n++;
        return n;
    endfunction

    function automatic int vec(input int c);
        return hist.exists(c) ? int'(hist[c]) : -1;
    endfunction

    task automatic run(input logic [7:0] k, input int n);
        keycode = k;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, any;
        repeat (2) @(negedge clk);
        check("reset_state", int'(dut_act), 0);
        check("reset_paused", int'(paused), 0);
        reset_n = 1'b1; enable = 1'b1;

        t0 = cyc; run(8'h00, 50);
        any = 0;
        for (int b = 0; b < 6; b++) any += npulse(b, t0 + 1, t0 + 50);
        check("idle_quiet", any, 0);

        t0 = cyc; run(8'h50, 40); run(8'h00, 30);
        check("left@4", vec(t0 + 4), 1);
        check("left_das_gap", npulse(0, t0 + 5, t0 + 13), 0);
        check("left@14", vec(t0 + 14), 1);
        check("left@18", vec(t0 + 18), 1);
        check("left@22", vec(t0 + 22), 1);
        check("left@26", vec(t0 + 26), 1);
        check("left_total", npulse(0, t0 + 1, t0 + 43), 9);
        check("left_after_release", npulse(0, t0 + 44, t0 + 70), 0);

        t0 = cyc; run(8'h52, 30); run(8'h00, 10);
        check("cw@4", vec(t0 + 4), 4);
        check("cw_once", npulse(2, t0 + 1, t0 + 40), 1);

        t0 = cyc; run(8'h50, 20); run(8'h4F, 20); run(8'h00, 20);
        check("swap_left@18", vec(t0 + 18), 1);
        check("swap_right@24", vec(t0 + 24), 2);
        check("swap_no_left", npulse(0, t0 + 24, t0 + 60), 0);
        check("swap_right_das_gap", npulse(1, t0 + 25, t0 + 33), 0);
        check("swap_right@34", vec(t0 + 34), 2);

        t0 = cyc; run(8'h2C, 1); run(8'h00, 10);
        check("glitch_no_hard", npulse(5, t0 + 1, t0 + 11), 0);

        t0 = cyc; run(8'h51, 9);
        enable = 1'b0; run(8'h51, 11);
        enable = 1'b1; run(8'h51, 15); run(8'h00, 10);
        check("soft@4", vec(t0 + 4), 16);
        check("soft@7", vec(t0 + 7), 16);
        check("soft_disabled", npulse(4, t0 + 8, t0 + 23), 0);
        check("soft@24", vec(t0 + 24), 16);
        check("soft@27", vec(t0 + 27), 16);
        check("soft@30", vec(t0 + 30), 16);

        t0 = cyc; run(8'h50, 14);
        check("left_before_reset", int'(dut_act), 1);
        reset_n = 1'b0; #1;
        check("reset_async", int'(dut_act), 0);
        @(negedge clk);
        reset_n = 1'b1; run(8'h00, 20);
        check("reset_abort", npulse(0, t0 + 15, t0 + 35), 0);

`ifdef KEY_ACTION_PAUSE_EN
        t0 = cyc; run(8'h29, 5); run(8'h00, 5); run(8'h50, 20);
        check("pause_set", int'(paused), 1);
        check("pause_no_left", npulse(0, t0 + 1, t0 + 30), 0);
        run(8'h00, 5); run(8'h29, 5); run(8'h00, 5);
        check("pause_clear", int'(paused), 0);
        t0 = cyc; run(8'h50, 10); run(8'h00, 10);
        check("unpause_left@4", vec(t0 + 4), 1);
`endif

        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
            end else if (r < 12) enable = !enable;
            run(KEYS[$urandom_range(0, 9)], $urandom_range(1, 24));
        end
        enable = 1'b1; run(8'h00, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
